alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake, iterative MUL and optional DIV.
// Define ALU_SEQ_DIV_EN to include the restoring divider; otherwise op 15 returns ERR_CODE.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] ERR_CODE = WIDTH'(8'hEE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu,
  output logic             out_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               r_state;
  logic [5:0]           r_cnt;
  logic [WIDTH-1:0]     r_alu;
  logic                 r_err;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_nx;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_raw;
  logic                 w_err;
  logic                 w_multi;
  logic                 w_acc;
  logic                 w_last;
  logic                 w_mul_ovf;
  logic [WIDTH-1:0]     w_bres;
  logic                 w_berr;
`ifdef ALU_SEQ_DIV_EN
  logic                 r_is_div;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvsr;
  logic [WIDTH:0]       w_sh;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_quo_nx;
`endif

  assign out_valid = r_state == DONE;
  assign out_alu   = r_alu;
  assign out_err   = r_err;
  assign in_ready  = !rst && (r_state == IDLE || (r_state == DONE && out_ready));
  assign w_acc     = in_valid && in_ready;
  assign w_last    = r_cnt == 6'(WIDTH - 1);
  assign w_sum     = {1'b0, sw_a} + {1'b0, sw_b};
  assign w_acc_nx  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_ovf = |w_acc_nx[2*WIDTH-1:WIDTH];

`ifdef ALU_SEQ_DIV_EN
  assign w_sh     = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_sh - {1'b0, r_dvsr};
  assign w_quo_nx = {r_quo[WIDTH-2:0], !w_diff[WIDTH]};
  assign w_multi  = op == 4'd14 || (op == 4'd15 && sw_b != '0);
  assign w_bres   = r_is_div ? w_quo_nx : (w_mul_ovf ? ERR_CODE : w_acc_nx[WIDTH-1:0]);
  assign w_berr   = !r_is_div && w_mul_ovf;
`else
  assign w_multi  = op == 4'd14;
  assign w_bres   = w_mul_ovf ? ERR_CODE : w_acc_nx[WIDTH-1:0];
  assign w_berr   = w_mul_ovf;
`endif

  // single-cycle result and error flag for the op currently on the inputs
  always_comb begin
    w_raw = '0;
    w_err = 1'b0;
    case (op)
      4'd0:  w_raw = sw_a & sw_b;
      4'd1:  w_raw = sw_a | sw_b;
      4'd2:  begin w_raw = w_sum[WIDTH-1:0]; w_err = w_sum[WIDTH]; end
      4'd3:  begin w_raw = sw_a - sw_b; w_err = sw_a <= sw_b; end
      4'd4:  w_raw = sw_a << sw_b;
      4'd5:  w_raw = sw_a >> sw_b;
      4'd6:  w_raw = $signed(sw_a) >>> sw_b;
      4'd7:  w_raw = sw_a ^ sw_b;
      4'd8:  w_raw = WIDTH'(sw_a == sw_b);
      4'd9:  w_raw = WIDTH'(sw_a >= sw_b);
      4'd10: w_raw = WIDTH'(sw_a < sw_b);
      4'd11: w_raw = sw_a > sw_b ? sw_a : sw_b;
      4'd12: w_raw = sw_a < sw_b ? sw_a : sw_b;
      4'd13: w_raw = sw_a + WIDTH'(4);
      4'd14: w_raw = '0;
`ifdef ALU_SEQ_DIV_EN
      default: w_err = sw_b == '0;
`else
      default: w_err = 1'b1;
`endif
    endcase
  end

  // handshake FSM, operand capture and one shift-add / restoring-divide step per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_alu    <= '0;
      r_err    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`ifdef ALU_SEQ_DIV_EN
      r_is_div <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
`endif
    end else if (w_acc) begin
      r_state  <= w_multi ? BUSY : DONE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, sw_a};
      r_mplier <= sw_b;
`ifdef ALU_SEQ_DIV_EN
      r_is_div <= op[0];
      r_rem    <= '0;
      r_quo    <= sw_a;
      r_dvsr   <= sw_b;
`endif
      if (!w_multi) begin
        r_alu <= w_err ? ERR_CODE : w_raw;
        r_err <= w_err;
      end
    end else if (r_state == BUSY) begin
      r_cnt    <= r_cnt + 6'd1;
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
`ifdef ALU_SEQ_DIV_EN
      r_rem    <= w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      r_quo    <= w_quo_nx;
`endif
      if (w_last) begin
        r_state <= DONE;
        r_alu   <= w_bres;
        r_err   <= w_berr;
      end
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with an arithmetic reference model and scoreboard.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_err;
  logic [3:0] op = '0;
  logic [W-1:0] sw_a = '0, sw_b = '0, out_alu;
  int tests = 0, fails = 0, cyc = 0;
  bit rnd_rdy = 1'b0, prev_valid = 1'b0;
  typedef struct {logic [7:0] r; logic e; int due; bit seen;} exp_t;
  exp_t q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .sw_a(sw_a), .sw_b(sw_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic e, output int lat);
    int ia, ib, sa, v;
    ia = int'(a); ib = int'(b); sa = a[7] ? ia - 256 : ia; v = 0; e = 1'b0; lat = 1;
    case (o)
      4'd0:  v = int'(a & b);
      4'd1:  v = int'(a | b);
      4'd2:  begin v = ia + ib; e = v > 255; end
      4'd3:  begin v = ia - ib; e = ia <= ib; end
      4'd4:  v = ib >= 8 ? 0 : ia * (1 << ib);
      4'd5:  v = ib >= 8 ? 0 : ia / (1 << ib);
      4'd6:  v = ib >= 8 ? (sa < 0 ? -1 : 0) : (sa >>> ib);
      4'd7:  v = int'(a ^ b);
      4'd8:  v = ia == ib ? 1 : 0;
      4'd9:  v = ia >= ib ? 1 : 0;
      4'd10: v = ia < ib ? 1 : 0;
      4'd11: v = ia > ib ? ia : ib;
      4'd12: v = ia < ib ? ia : ib;
      4'd13: v = ia + 4;
      4'd14: begin v = ia * ib; e = v > 255; lat = W + 1; end
      default: if (!DIV_EN || ib == 0) e = 1'b1; else begin v = ia / ib; lat = W + 1; end
    endcase
    r = e ? 8'hEE : 8'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard: retire on handshake, check every valid cycle and first-valid latency
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (out_valid) begin
        if (q.size() == 0) chk("sb_spurious_valid", 32'(out_valid), 0);
        else begin
          if (!q[0].seen) begin chk("sb_latency_cycle", cyc, q[0].due); q[0].seen = 1'b1; end
          chk("sb_alu", 32'(out_alu), 32'(q[0].r));
          chk("sb_err", 32'(out_err), 32'(q[0].e));
        end
      end
      prev_valid = out_valid;
    end
  end

  always @(negedge clk) if (rnd_rdy) out_ready = 1'($urandom_range(1, 0));

  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t x;
    int lat, n;
    @(negedge clk);
    in_valid = 1'b1; op = o; sw_a = a; sw_b = b;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 for op %0d", o);
    end else begin
      model(o, a, b, x.r, x.e, lat);
      x.due = cyc + lat;
      x.seen = 1'b0;
      q.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); sw_a = 8'($urandom); sw_b = 8'($urandom);
  endtask

  task automatic wait_valid(input string name, input logic [7:0] er, input logic ee, input int elat);
    int n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk({name, "_valid"}, 32'(out_valid), 1);
    chk({name, "_latency"}, n + 1, elat);
    chk({name, "_alu"}, 32'(out_alu), 32'(er));
    chk({name, "_err"}, 32'(out_err), 32'(ee));
  endtask

  task automatic pin(input string name, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] er, input logic ee, input int el);
    logic [7:0] r; logic e; int l;
    model(o, a, b, r, e, l);
    chk({name, "_model_alu"}, 32'(r), 32'(er));
    chk({name, "_model_err"}, 32'(e), 32'(ee));
    chk({name, "_model_lat"}, l, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pa[4] = '{8'hC3, 8'h05, 8'h80, 8'hFF};
    logic [7:0] pb[4] = '{8'h05, 8'hC3, 8'h00, 8'hFF};
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_alu", 32'(out_alu), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);
    pin("add_ovf", 4'd2, 8'hF0, 8'h20, 8'hEE, 1'b1, 1);
    pin("mul", 4'd14, 8'h0F, 8'h11, 8'hFF, 1'b0, 9);
    pin("sra", 4'd6, 8'h90, 8'h03, 8'hF2, 1'b0, 1);
    pin("sub_eq", 4'd3, 8'h05, 8'h05, 8'hEE, 1'b1, 1);
    pin("div", 4'd15, 8'd200, 8'd7, DIV_EN ? 8'h1C : 8'hEE, !DIV_EN, DIV_EN ? 9 : 1);

    issue(4'd2, 8'hF0, 8'h20);  wait_valid("add_ovf", 8'hEE, 1'b1, 1);
    issue(4'd2, 8'h70, 8'h0F);  wait_valid("add", 8'h7F, 1'b0, 1);
    issue(4'd14, 8'h0F, 8'h11); wait_valid("mul", 8'hFF, 1'b0, 9);
    issue(4'd14, 8'h10, 8'h10); wait_valid("mul_ovf", 8'hEE, 1'b1, 9);

    issue(4'd15, 8'd200, 8'd7);
    @(negedge clk); out_ready = 1'b0;
    wait_valid("div", DIV_EN ? 8'h1C : 8'hEE, !DIV_EN, DIV_EN ? 9 : 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_alu", 32'(out_alu), DIV_EN ? 32'h1C : 32'hEE);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk); out_ready = 1'b1;
    issue(4'd15, 8'h33, 8'h00); wait_valid("div0", 8'hEE, 1'b1, 1);

    issue(4'd4, 8'h01, 8'h08);  wait_valid("shl8", 8'h00, 1'b0, 1);
    issue(4'd6, 8'h90, 8'h03);  wait_valid("sra3", 8'hF2, 1'b0, 1);
    issue(4'd6, 8'h90, 8'h09);  wait_valid("sra9", 8'hFF, 1'b0, 1);

    issue(4'd14, 8'h0F, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_alu", 32'(out_alu), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_after", 32'(in_ready), 1);
    chk("abort_no_result", 32'(out_valid), 0);
    issue(4'd8, 8'h5A, 8'h5A); wait_valid("eq", 8'h01, 1'b0, 1);

    for (int p = 0; p < 4; p++) begin
      if (p == 2) rnd_rdy = 1'b1;
      for (int i = 0; i < 16; i++) issue(4'(i), pa[p], pb[p]);
    end
    rnd_rdy = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
